// File: rtl/gcu_dep_scoreboard.sv
// GCU dependency scoreboard: per-node pending-children counters.
// A node is front ready once every child has reported scatter completion.
module gcu_dep_scoreboard #(
  parameter int NODE_ID_W   = 4,
  parameter int MAX_NODES   = 8,
  parameter int CHILD_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_valid,
  input  logic [NODE_ID_W-1:0]   init_node_id,
  input  logic [CHILD_CNT_W-1:0] init_children_count,
  input  logic                   scatter_done_valid,
  input  logic [NODE_ID_W-1:0]   scatter_done_child_id,
  input  logic [NODE_ID_W-1:0]   scatter_done_parent_id,
  input  logic                   query_valid,
  input  logic [NODE_ID_W-1:0]   query_node_id,
  output logic                   front_ready,
  output logic [CHILD_CNT_W-1:0] pending_children_count
);

  logic                   valid_q [MAX_NODES];
  logic [CHILD_CNT_W-1:0] cnt_q   [MAX_NODES];

  // Child id is carried for tracing only.
  logic unused_child;
  assign unused_child = ^scatter_done_child_id;

  logic [MAX_NODES-1:0] init_hit;
  logic [MAX_NODES-1:0] dec_hit;

  // Ids >= MAX_NODES never match any entry, so they are dropped.
  always_comb begin
    init_hit = '0;
    dec_hit  = '0;
    for (int i = 0; i < MAX_NODES; i++) begin
      init_hit[i] = init_valid &&
                    (init_node_id == NODE_ID_W'(i));
      dec_hit[i]  = scatter_done_valid &&
                    (scatter_done_parent_id == NODE_ID_W'(i)) &&
                    valid_q[i] && (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_NODES; i++) begin
        if (init_hit[i]) begin
          valid_q[i] <= 1'b1;
          cnt_q[i]   <= init_children_count;
        end else if (dec_hit[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    front_ready            = 1'b0;
    pending_children_count = '0;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (query_valid && valid_q[i] &&
          (query_node_id == NODE_ID_W'(i))) begin
        pending_children_count = cnt_q[i];
        front_ready            = (cnt_q[i] == '0);
      end
    end
  end

endmodule

// File: tb/tb_gcu_dep_scoreboard.sv
// Bench for gcu_dep_scoreboard: directed vector table, then random
// traffic against an array-based reference model.
module tb_gcu_dep_scoreboard;

  localparam int NW = 4;
  localparam int MN = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_valid;
  logic [NW-1:0] init_node_id;
  logic [CW-1:0] init_children_count;
  logic          scatter_done_valid;
  logic [NW-1:0] scatter_done_child_id;
  logic [NW-1:0] scatter_done_parent_id;
  logic          query_valid;
  logic [NW-1:0] query_node_id;
  logic          front_ready;
  logic [CW-1:0] pending_children_count;

  always #5 clk = ~clk;

  gcu_dep_scoreboard #(
    .NODE_ID_W(NW), .MAX_NODES(MN), .CHILD_CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .init_valid(init_valid),
    .init_node_id(init_node_id),
    .init_children_count(init_children_count),
    .scatter_done_valid(scatter_done_valid),
    .scatter_done_child_id(scatter_done_child_id),
    .scatter_done_parent_id(scatter_done_parent_id),
    .query_valid(query_valid),
    .query_node_id(query_node_id),
    .front_ready(front_ready),
    .pending_children_count(pending_children_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain per-node flags and integer counts.
  bit m_val [16];
  int m_cnt [16];

  typedef struct {
    bit rst;
    bit iv; int iid; int icnt;
    bit sv; int sp;
    bit qv; int qid;
    int exp_p; bit exp_f;
  } vec_t;

  task automatic model_edge();
    int ii;
    int pp;
    ii = int'(init_node_id);
    pp = int'(scatter_done_parent_id);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_val[i] = 0;
        m_cnt[i] = 0;
      end
    end else begin
      if (scatter_done_valid && pp < MN && m_val[pp] && m_cnt[pp] > 0 &&
          !(init_valid && ii == pp))
        m_cnt[pp] = m_cnt[pp] - 1;
      if (init_valid && ii < MN) begin
        m_val[ii] = 1;
        m_cnt[ii] = int'(init_children_count);
      end
    end
  endtask

  task automatic check(string name, int exp_p, bit exp_f);
    n_checks++;
    if (int'(pending_children_count) != exp_p ||
        front_ready != exp_f) begin
      n_fail++;
      $display("FAIL %s: got pending=%0d ready=%0b, want pending=%0d ready=%0b",
               name, pending_children_count, front_ready, exp_p, exp_f);
    end
  endtask

  task automatic drive(bit r, bit iv, int iid, int icnt,
                       bit sv, int sp, bit qv, int qid);
    rst                    = r;
    init_valid             = iv;
    init_node_id           = NW'(iid);
    init_children_count    = CW'(icnt);
    scatter_done_valid     = sv;
    scatter_done_child_id  = NW'($urandom_range(0, 15));
    scatter_done_parent_id = NW'(sp);
    query_valid            = qv;
    query_node_id          = NW'(qid);
  endtask

  task automatic model_expect(output int p, output bit f);
    int q;
    q = int'(query_node_id);
    p = 0;
    f = 0;
    if (query_valid && q < MN && m_val[q]) begin
      p = m_cnt[q];
      f = (m_cnt[q] == 0);
    end
  endtask

  vec_t vt [19];

  initial begin
    int ep;
    bit ef;
    // rst iv id cnt  sv sp  qv qid  exp_p exp_f
    vt[0]  = '{0, 1, 1, 0,     0, 0, 1, 1, 0,     0};
    vt[1]  = '{0, 1, 2, 2,     0, 0, 1, 1, 0,     1};
    vt[2]  = '{0, 0, 0, 0,     0, 0, 1, 1, 0,     1};
    vt[3]  = '{0, 0, 0, 0,     1, 2, 1, 2, 2,     0};
    vt[4]  = '{0, 0, 0, 0,     1, 2, 1, 2, 1,     0};
    vt[5]  = '{0, 0, 0, 0,     1, 2, 1, 2, 0,     1};
    vt[6]  = '{0, 0, 0, 0,     1, 6, 1, 2, 0,     1};
    vt[7]  = '{0, 1, 5, 7,     0, 0, 1, 6, 0,     0};
    vt[8]  = '{0, 1, 5, 3,     1, 5, 1, 5, 7,     0};
    vt[9]  = '{0, 1, 9, 1,     1, 5, 1, 5, 3,     0};
    vt[10] = '{0, 1, 3, 1,     1, 5, 1, 9, 0,     0};
    vt[11] = '{0, 1, 7, 65535, 0, 0, 1, 5, 1,     0};
    vt[12] = '{0, 0, 0, 0,     0, 0, 0, 3, 0,     0};
    vt[13] = '{0, 0, 0, 0,     1, 7, 1, 7, 65535, 0};
    vt[14] = '{1, 1, 4, 4,     1, 7, 1, 3, 1,     0};
    vt[15] = '{0, 0, 0, 0,     0, 0, 1, 3, 0,     0};
    vt[16] = '{0, 0, 0, 0,     0, 0, 1, 5, 0,     0};
    vt[17] = '{0, 0, 0, 0,     0, 0, 1, 4, 0,     0};
    vt[18] = '{0, 0, 0, 0,     0, 0, 1, 7, 0,     0};

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (100) @(posedge clk);
    model_edge();
    #1;

    foreach (vt[k]) begin
      drive(vt[k].rst, vt[k].iv, vt[k].iid, vt[k].icnt,
            vt[k].sv, vt[k].sp, vt[k].qv, vt[k].qid);
      @(negedge clk);
      check($sformatf("vec%0d", k), vt[k].exp_p, vt[k].exp_f);
      @(posedge clk);
      model_edge();
      #1;
    end

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 10),
            $urandom_range(0, 4),
            ($urandom_range(0, 1) == 1), $urandom_range(0, 9),
            ($urandom_range(0, 7) != 0), $urandom_range(0, 15));
      @(negedge clk);
      model_expect(ep, ef);
      check($sformatf("rand%0d", n), ep, ef);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcu_dep_scoreboard.md
Name: gcu_dep_scoreboard

Overview:
Dependency scoreboard for the GCU. It tracks, per graph node, how many child nodes still have to finish their Scatter phase. A node is declared "front ready" once all its children have reported scatter completion. Upstream control initialises entries, the scatter engine reports completions, and the scheduler queries readiness.

Parameters:
NODE_ID_W, 4, width of every node-id field.
MAX_NODES, 8, number of scoreboard entries; valid node ids are 0..MAX_NODES-1, and MAX_NODES must be ≤ 2**NODE_ID_W.
CHILD_CNT_W, 16, width of the pending-children counter and of the count ports.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
init_valid  in  1  strobe that (re)initialises one entry.
init_node_id  in  NODE_ID_W  entry to initialise.
init_children_count  in  CHILD_CNT_W  number of children the node must wait for.
scatter_done_valid  in  1  strobe: one child finished its scatter.
scatter_done_child_id  in  NODE_ID_W  finishing child; informational only, no state depends on it.
scatter_done_parent_id  in  NODE_ID_W  parent whose counter is decremented.
query_valid  in  1  query strobe.
query_node_id  in  NODE_ID_W  entry to query.
front_ready  out  1  queried node is initialised and has 0 pending children.
pending_children_count  out  CHILD_CNT_W  pending count of the queried node.

Behaviour:
- State per entry i: valid_i (1 bit) and cnt_i (CHILD_CNT_W bits).
- Reset (rst=1 at a rising edge):
  - all valid_i=0 and cnt_i=0;
  - outputs read 0 while entries are invalid.
- Init: when init_valid=1 and init_node_id<MAX_NODES, at the next edge valid=1 and cnt=init_children_count.
  - Re-init overwrites any existing entry.
  - An id ≥ MAX_NODES is ignored.
- Scatter done: when scatter_done_valid=1, the parent id is <MAX_NODES, the entry is valid and cnt>0, then cnt decrements by 1 at the next edge.
  - cnt saturates at 0; no underflow.
  - A completion to an invalid or out-of-range parent is dropped.
- Simultaneous init and scatter_done to the same entry in one cycle: init wins and the decrement is discarded.
- Simultaneous init and scatter_done to different entries: both take effect.
- Query: outputs are purely combinational from the current registered state, so they are valid in the same cycle as query_valid (0-cycle latency).
  - With query_valid=1, an in-range id and a valid entry: pending_children_count=cnt and front_ready=(cnt==0).
  - In every other case (query_valid=0, invalid entry, or out-of-range id): front_ready=0 and pending_children_count=0.
- Visibility of updates: an init or decrement applied at edge N is visible to queries from just after edge N; no combinational bypass from the init or scatter inputs to the outputs.
- Entries are never freed except by rst or by a re-init.
- rst asserted mid-operation clears all entries at that edge. Strobes in the same cycle as rst are ignored.

Test Plan:
- Reset for 100 cycles, then query node 1 -> front_ready=0, pending=0 (entry not initialised).
- init(1,0), then query 1 -> pending=0, front_ready=1; query 1 again later -> still 1.
- init(2,2), then query 2 -> pending=2, front_ready=0. scatter_done(3,2), then query 2 -> pending=1, front_ready=0. scatter_done(4,2), then query 2 -> pending=0, front_ready=1.
- A further scatter_done(5,2) on node 2 at 0 -> stays pending=0 (saturation). scatter_done to uninitialised node 6 -> node 6 query still 0/0.
- Same-cycle init(5,3) and scatter_done(x,5) -> pending=3. init(9,1) with MAX_NODES=8 -> ignored, query 9 returns 0/0.
- Query with query_valid=0 -> outputs 0. Assert rst after nodes are set up -> every query returns 0/0.
